multi_point_tracker: RTL

- Streaming detector for bright-spot points: takes a per-pixel brightness bit alongside VGA x/y and extracts horizontal runs of bright pixels.
- Runs are linked into vertically connected blobs across lines, up to MAX_PTS blobs per frame.
- For each blob it keeps the centre of its widest run, so points spanning many lines yield one correct centre rather than a half-blob.
- After frame end it reports the point table over a valid/ready stream to the detection controller / coordinate store.

---
 rtl/multi_point_tracker.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_point_tracker.sv
// Streaming bright-spot tracker: extracts horizontal runs of bright pixels, links them into
// vertically connected blobs, and reports each blob's widest-run centre after frame end.
module multi_point_tracker #(
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int MAX_PTS   = 4,
    parameter int MIN_WIDTH = 2,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_start,
    input  logic             i_frame_end,
    input  logic             i_pix_valid,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    input  logic             i_bright,
    input  logic             i_pt_ready,
    output logic             o_pt_valid,
    output logic [X_W-1:0]   o_pt_x,
    output logic [Y_W-1:0]   o_pt_y,
    output logic [X_W-1:0]   o_pt_width,
    output logic [IDX_W-1:0] o_pt_idx,
    output logic             o_done,
    output logic [IDX_W-1:0] o_count,
    output logic             o_overflow,
    output logic             o_busy
);
    localparam int SW  = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;
    localparam int PW  = IDX_W + 1;
    localparam int YW1 = Y_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT, S_DONE} state_t;
    state_t state, state_nxt;

    // Run being accumulated on the current line
    logic           run_open;
    logic [X_W-1:0] run_start, run_end;
    logic [Y_W-1:0] run_y;
    // Closed run waiting for its commit into the slot table
    logic           cm_valid;
    logic [X_W-1:0] cm_start, cm_end, cm_width;
    logic [Y_W-1:0] cm_y;
    logic           flush;
    logic [PW-1:0]  ptr;
    logic           overflow;

    logic [MAX_PTS-1:0] active;
    logic [X_W-1:0]     s_start [MAX_PTS];
    logic [X_W-1:0]     s_end   [MAX_PTS];
    logic [X_W-1:0]     s_max   [MAX_PTS];
    logic [X_W-1:0]     s_cx    [MAX_PTS];
    logic [Y_W-1:0]     s_last  [MAX_PTS];
    logic [Y_W-1:0]     s_cy    [MAX_PTS];

    logic [X_W-1:0] run_width, cm_cx;
    logic           run_keep, scanning, close_now, open_now, extend;
    logic           m_found, f_found, sel_found, xfer;
    logic [SW-1:0]  m_idx, f_idx, sel;
    logic [IDX_W-1:0] cnt;

    assign run_width = run_end - run_start + X_W'(1);
    assign run_keep  = run_width >= X_W'(MIN_WIDTH);
    assign cm_cx     = cm_start + (cm_width >> 1);

    // A line change closes the open run and may open the next one in the same cycle
    assign scanning  = (state == S_SCAN) && !flush;
    assign close_now = scanning && run_open &&
                       (i_frame_end || (i_pix_valid && (!i_bright || i_y != run_y)));
    assign open_now  = scanning && !i_frame_end && i_pix_valid && i_bright &&
                       (!run_open || i_y != run_y);
    assign extend    = scanning && !i_frame_end && i_pix_valid && i_bright &&
                       run_open && i_y == run_y;

    // Slots already touched on cm_y fail the last_y+1 test, so they cannot take a second run
    always_comb begin
        m_found = 1'b0;
        m_idx   = '0;
        f_found = 1'b0;
        f_idx   = '0;
        for (int i = MAX_PTS - 1; i >= 0; i--) begin
            if (active[i] && ({1'b0, s_last[i]} + YW1'(1) == {1'b0, cm_y}) &&
                cm_start <= s_end[i] && cm_end >= s_start[i]) begin
                m_found = 1'b1;
                m_idx   = SW'(i);
            end
            if (!active[i]) begin
                f_found = 1'b1;
                f_idx   = SW'(i);
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cnt       = '0;
        for (int i = MAX_PTS - 1; i >= 0; i--) begin
            if (active[i] && PW'(i) >= ptr) begin
                sel_found = 1'b1;
                sel       = SW'(i);
            end
            cnt = cnt + IDX_W'(active[i]);
        end
    end

    // o_pt_* derive from slot registers and ptr, which only move on a transfer
    assign o_pt_valid = (state == S_REPORT) && sel_found;
    assign xfer       = o_pt_valid && i_pt_ready;
    assign o_pt_x     = o_pt_valid ? s_cx[sel]   : '0;
    assign o_pt_y     = o_pt_valid ? s_cy[sel]   : '0;
    assign o_pt_width = o_pt_valid ? s_max[sel]  : '0;
    assign o_pt_idx   = o_pt_valid ? IDX_W'(sel) : '0;
    assign o_done     = (state == S_DONE);
    assign o_count    = o_done ? cnt : '0;
    assign o_overflow = overflow;
    assign o_busy     = (state == S_SCAN) || (state == S_REPORT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (i_frame_start) state_nxt = S_SCAN;
            S_SCAN:   if (flush) state_nxt = S_REPORT;
            S_REPORT: if (!sel_found) state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_open  <= 1'b0;
            run_start <= '0;
            run_end   <= '0;
            run_y     <= '0;
            cm_valid  <= 1'b0;
            cm_start  <= '0;
            cm_end    <= '0;
            cm_width  <= '0;
            cm_y      <= '0;
            flush     <= 1'b0;
            ptr       <= '0;
            overflow  <= 1'b0;
            active    <= '0;
            for (int i = 0; i < MAX_PTS; i++) begin
                s_start[i] <= '0;
                s_end[i]   <= '0;
                s_max[i]   <= '0;
                s_cx[i]    <= '0;
                s_last[i]  <= '0;
                s_cy[i]    <= '0;
            end
        end else begin
            cm_valid <= 1'b0;
            if (state == S_IDLE && i_frame_start) begin
                active   <= '0;
                overflow <= 1'b0;
                run_open <= 1'b0;
                flush    <= 1'b0;
                ptr      <= '0;
            end
            if (scanning && i_frame_end) flush <= 1'b1;
            if (close_now) begin
                cm_valid <= run_keep;
                cm_start <= run_start;
                cm_end   <= run_end;
                cm_width <= run_width;
                cm_y     <= run_y;
            end
            if (open_now) begin
                run_open  <= 1'b1;
                run_start <= i_x;
                run_end   <= i_x;
                run_y     <= i_y;
            end else if (close_now) begin
                run_open <= 1'b0;
            end else if (extend) begin
                run_end <= i_x;
            end
            if (cm_valid && state == S_SCAN) begin
                if (m_found) begin
                    s_start[m_idx] <= cm_start;
                    s_end[m_idx]   <= cm_end;
                    s_last[m_idx]  <= cm_y;
                    if (cm_width > s_max[m_idx]) begin
                        s_max[m_idx] <= cm_width;
                        s_cx[m_idx]  <= cm_cx;
                        s_cy[m_idx]  <= cm_y;
                    end
                end else if (f_found) begin
                    active[f_idx]  <= 1'b1;
                    s_start[f_idx] <= cm_start;
                    s_end[f_idx]   <= cm_end;
                    s_last[f_idx]  <= cm_y;
                    s_max[f_idx]   <= cm_width;
                    s_cx[f_idx]    <= cm_cx;
                    s_cy[f_idx]    <= cm_y;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (xfer) ptr <= PW'(sel) + PW'(1);
        end
    end
endmodule
